// File: rtl/atan2_cordic.sv
// Iterative CORDIC vectoring engine returning atan2(y, x) and sqrt(x^2 + y^2)
// in signed fixed point, with ready/valid handshakes on both sides.
module atan2_cordic #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ITERS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_angle,
    output logic signed [WIDTH-1:0] out_mag
);

    localparam int unsigned ZW   = WIDTH + 2;
    localparam int unsigned IW   = $clog2(ITERS + 1);
    localparam int unsigned TABN = 2 ** IW;
    localparam int unsigned PW   = ZW + FRAC + 2;

    // pi with 60 fractional bits; angle constants are derived from it.
    localparam logic [63:0] PI60 = 64'h3243F6A8885A308D;

    function automatic logic [63:0] round_to_frac(input logic [63:0] v60);
        return (v60 + (64'd1 << (59 - FRAC))) >> (60 - FRAC);
    endfunction

    // atan(2^-i) with 60 fractional bits, from the alternating power series.
    function automatic logic [63:0] atan60(input int unsigned i);
        logic [63:0] acc;
        logic [63:0] term;
        int unsigned sh;
        if (i == 0) begin
            return PI60 >> 2;
        end
        acc = '0;
        for (int unsigned k = 0; k < 40; k++) begin
            sh = i * (2 * k + 1);
            if (sh < 61) begin
                term = (64'd1 << (60 - sh)) / 64'(2 * k + 1);
                if (k % 2 == 0) begin
                    acc = acc + term;
                end else begin
                    acc = acc - term;
                end
            end
        end
        return acc;
    endfunction

    function automatic logic [TABN-1:0][ZW-1:0] gen_atan_tab();
        logic [TABN-1:0][ZW-1:0] tab;
        tab = '0;
        for (int unsigned i = 0; i < ITERS; i++) begin
            tab[i[IW-1:0]] = ZW'(round_to_frac(atan60(i)));
        end
        return tab;
    endfunction

    localparam logic [TABN-1:0][ZW-1:0] ATAN_TAB = gen_atan_tab();
    localparam logic signed [ZW-1:0] PI_FX     = ZW'(round_to_frac(PI60));
    localparam logic signed [ZW-1:0] NEG_PI_FX = -PI_FX;
    localparam logic [63:0] K_RAW =
        (64'd6072529350 * (64'd1 << FRAC) + 64'd5000000000) / 64'd10000000000;
    localparam logic signed [PW-1:0] K_FX    = PW'(K_RAW);
    localparam logic signed [PW-1:0] MAG_MAX = PW'((64'd1 << (WIDTH - 1)) - 64'd1);

    typedef enum logic [2:0] {
        StIdle,
        StPrerot,
        StIter,
        StScale,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ZW-1:0]    x_q, x_d;
    logic signed [ZW-1:0]    y_q, y_d;
    logic signed [ZW-1:0]    z_q, z_d;
    logic [IW-1:0]           i_q, i_d;
    logic                    zero_q, zero_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] angle_q, angle_d;
    logic signed [WIDTH-1:0] mag_q, mag_d;

    logic signed [ZW-1:0] x_sh;
    logic signed [ZW-1:0] y_sh;
    logic signed [ZW-1:0] atan_i;
    logic signed [ZW-1:0] z_wrapped;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] mag_full;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        angle_d     = angle_q;
        mag_d       = mag_q;

        x_sh      = x_q >>> i_q;
        y_sh      = y_q >>> i_q;
        atan_i    = ATAN_TAB[i_q];
        // -pi folds onto +pi so the reported range is (-pi, pi].
        z_wrapped = (z_q <= NEG_PI_FX) ? PI_FX : z_q;
        prod      = PW'(x_q) * K_FX;
        mag_full  = prod >>> FRAC;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    x_d        = ZW'(in_x);
                    y_d        = ZW'(in_y);
                    zero_d     = (in_x == '0) && (in_y == '0);
                    in_ready_d = 1'b0;
                    state_d    = StPrerot;
                end
            end
            StPrerot: begin
                // Left half-plane: rotate by pi so iterations only cover (-pi/2, pi/2].
                if (x_q[ZW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[ZW-1] ? NEG_PI_FX : PI_FX;
                end else begin
                    z_d = '0;
                end
                i_d     = '0;
                state_d = StIter;
            end
            StIter: begin
                if (y_q[ZW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                if (i_q == IW'(ITERS - 1)) begin
                    state_d = StScale;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            StScale: begin
                angle_d = zero_q ? '0 : WIDTH'(z_wrapped);
                if (mag_full[PW-1]) begin
                    mag_d = '0;
                end else if (mag_full > MAG_MAX) begin
                    mag_d = WIDTH'(MAG_MAX);
                end else begin
                    mag_d = WIDTH'(mag_full);
                end
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            angle_q     <= angle_d;
            mag_q       <= mag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_angle = angle_q;
    assign out_mag   = mag_q;

endmodule

// File: tb/tb_atan2_cordic.sv
// Scoreboard bench for atan2_cordic: real-valued atan2/hypot model, directed
// corner vectors, backpressure, reset abort and a randomized back-to-back sweep.
module tb_atan2_cordic;

    localparam int  W       = 32;
    localparam int  F       = 16;
    localparam int  N       = 16;
    localparam real SCALE   = 65536.0;
    localparam real PI_R    = 3.14159265358979323846;
    localparam real KEXACT  = 0.6072529350;
    localparam int  ANG_TOL = 6;
    localparam int  MAG_TOL = 6;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] in_x      = '0;
    logic signed [W-1:0] in_y      = '0;
    logic                in_ready;
    logic                out_valid;
    logic signed [W-1:0] out_angle;
    logic signed [W-1:0] out_mag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int  x;
        int  y;
        real ang;
        real mag;
        bit  exact;
    } exp_t;

    exp_t sb[$];

    atan2_cordic #(
        .WIDTH(W),
        .FRAC (F),
        .ITERS(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_angle(out_angle),
        .out_mag  (out_mag)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        real  rx;
        real  ry;
        real  kq;
        rx      = real'(x);
        ry      = real'(y);
        // Scaling constant is quantised to the fraction width before use.
        kq      = $floor(KEXACT * SCALE + 0.5) / SCALE;
        e.x     = x;
        e.y     = y;
        e.ang   = $atan2(ry, rx) * SCALE;
        e.mag   = $sqrt(rx * rx + ry * ry) * kq / KEXACT;
        e.exact = (x == 0) && (y == 0);
        return e;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_result(input exp_t e, input int a, input int m);
        real d;
        bit  ok;
        int  pi_fx;
        pi_fx = $rtoi(PI_R * SCALE + 0.5);
        checks++;
        if (e.exact) begin
            ok = (a == 0);
        end else begin
            d = real'(a) - e.ang;
            if (d > PI_R * SCALE) d = d - 2.0 * PI_R * SCALE;
            else if (d < -PI_R * SCALE) d = d + 2.0 * PI_R * SCALE;
            ok = (d <= real'(ANG_TOL)) && (d >= -real'(ANG_TOL)) && (a > -pi_fx);
        end
        if (!ok) begin
            errors++;
            $display("FAIL angle x=%0d y=%0d got %0d expected %0.1f", e.x, e.y, a, e.ang);
        end
        checks++;
        if (e.exact) begin
            ok = (m == 0);
        end else begin
            d  = real'(m) - e.mag;
            ok = (d <= real'(MAG_TOL)) && (d >= -real'(MAG_TOL)) && (m >= 0);
        end
        if (!ok) begin
            errors++;
            $display("FAIL mag x=%0d y=%0d got %0d expected %0.1f", e.x, e.y, m, e.mag);
        end
    endtask

    // Monitor: every accepted result is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got angle %0d mag %0d expected none",
                         out_angle, out_mag);
            end else begin
                e = sb.pop_front();
                compare_result(e, out_angle, out_mag);
            end
        end
    end

    task automatic send(input int x, input int y, input bit push);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 expected 1 (x=%0d y=%0d)", x, y);
            return;
        end
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        if (push) sb.push_back(model(x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_int("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int lat;
        int cnt;
        int changes;
        int valid_lo;
        int ready_hi;
        int a0;
        int m0;
        int x;
        int y;
        int dx[6] = '{-65536, -65536, -65536, 0, 0, 0};
        int dy[6] = '{65536, -65536, 0, 65536, -65536, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_in_ready", int'(in_ready), 1);
        check_int("rst_out_angle", out_angle, 0);
        check_int("rst_out_mag", out_mag, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency from the accepting edge to out_valid.
        send(196608, 262144, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_int("latency", lat, N + 2);

        // Abort mid-iteration; the previous result must also be cleared.
        send(196608, -131072, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_int("abort_out_valid", int'(out_valid), 0);
        check_int("abort_in_ready", int'(in_ready), 1);
        check_int("abort_out_angle", out_angle, 0);
        check_int("abort_out_mag", out_mag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check_int("abort_no_result", cnt, 0);
        send(65536, 65536, 1'b1);

        for (int i = 0; i < 6; i++) send(dx[i], dy[i], 1'b1);
        drain();

        // Backpressure: result held, new requests refused until consumed.
        out_ready = 1'b0;
        send(-131072, 327680, 1'b1);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_int("bp_valid_seen", int'(out_valid), 1);
        a0       = out_angle;
        m0       = out_mag;
        changes  = 0;
        valid_lo = 0;
        ready_hi = 0;
        in_x     = 12345;
        in_y     = -54321;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_angle != a0 || out_mag != m0) changes++;
            if (!out_valid) valid_lo++;
            if (in_ready) ready_hi++;
        end
        check_int("bp_hold_stable", changes, 0);
        check_int("bp_valid_held", valid_lo, 0);
        check_int("bp_in_ready_low", ready_hi, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_int("bp_valid_drop", int'(out_valid), 0);
        check_int("bp_in_ready_back", int'(in_ready), 1);
        cnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check_int("bp_request_ignored", cnt, 0);

        // Random back-to-back sweep; tiny vectors are skipped for resolution.
        for (int n = 0; n < 1000; n++) begin
            do begin
                x = int'($urandom_range(0, 2097150)) - 1048575;
                y = int'($urandom_range(0, 2097150)) - 1048575;
            end while ($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) < 131072.0);
            send(x, y, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
